// File: rtl/lsm_reservoir_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : lsm_reservoir_param
// Description : Ring-connected leaky integrate-and-fire reservoir with a
//               trainable signed readout layer. One reservoir timestep is
//               processed per request, one neuron per cycle, followed by a
//               single-cycle readout and an optional single-cycle learning pass.
// Revision    : 1.0 - initial release
// ============================================================================
module lsm_reservoir_param #(
  parameter int N_NEURONS  = 16,
  parameter int N_EXT      = 8,
  parameter int N_OUT      = 2,
  parameter int V_WIDTH    = 12,
  parameter int W_WIDTH    = 4,
  parameter int W_EXT      = 64,
  parameter int W_REC      = 32,
  parameter int THRESH     = 256,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRAC     = 2,
  parameter int OUT_THRESH = 4,
  parameter int W_INIT     = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_EXT-1:0]     ext_in,
  input  logic                 step_valid,
  output logic                 step_ready,
  input  logic                 write,
  input  logic [N_OUT-1:0]     teacher,
  output logic [N_NEURONS-1:0] spike_record,
  output logic [N_OUT-1:0]     out_spikes,
  output logic                 step_done
);

  localparam int IW = $clog2(N_NEURONS);
  localparam int RW = (REFRAC < 1) ? 1 : $clog2(REFRAC + 1);
  // Headroom so leak/increment arithmetic never overflows before saturation
  localparam int SW = V_WIDTH + 16;

  localparam logic [2:0] c_idle    = 3'd0;
  localparam logic [2:0] c_update  = 3'd1;
  localparam logic [2:0] c_readout = 3'd2;
  localparam logic [2:0] c_learn   = 3'd3;
  localparam logic [2:0] c_done    = 3'd4;

  localparam logic [V_WIDTH-1:0]        c_v_max  = '1;
  localparam logic signed [W_WIDTH-1:0] c_w_max  = {1'b0, {(W_WIDTH-1){1'b1}}};
  localparam logic signed [W_WIDTH-1:0] c_w_min  = {1'b1, {(W_WIDTH-1){1'b0}}};
  localparam logic signed [W_WIDTH-1:0] c_w_one  = 1;
  localparam logic signed [W_WIDTH-1:0] c_w_init = W_WIDTH'(W_INIT);

  logic [2:0]           r_state;
  logic [IW-1:0]        r_idx;
  logic [N_EXT-1:0]     r_ext;
  logic                 r_write;
  logic [N_OUT-1:0]     r_teacher;
  logic [N_NEURONS-1:0] r_shadow;

  logic [V_WIDTH-1:0]        r_v   [N_NEURONS];
  logic [RW-1:0]             r_ref [N_NEURONS];
  logic signed [W_WIDTH-1:0] r_w   [N_OUT][N_NEURONS];

  logic                 w_accept;
  logic [N_NEURONS-1:0] w_ext_bit;
  logic [N_NEURONS-1:0] w_left;
  logic [N_NEURONS-1:0] w_right;
  logic [SW-1:0]        w_in;
  logic [SW-1:0]        w_v_ext;
  logic [SW-1:0]        w_v_new;
  logic [V_WIDTH-1:0]   w_v_sat;
  logic                 w_refr;
  logic                 w_fire;
  logic [N_OUT-1:0]     w_out_next;
  int                   w_acc;

  assign step_ready = (r_state == c_idle);
  assign step_done  = (r_state == c_done);
  assign w_accept   = step_valid && step_ready;

  // Per-neuron input taps: external channel wraps modulo N_EXT, neighbours
  // come from the previous step's spike record around the ring
  for (genvar n = 0; n < N_NEURONS; n++) begin : g_taps
    assign w_ext_bit[n] = r_ext[n % N_EXT];
    assign w_left[n]    = spike_record[(n + N_NEURONS - 1) % N_NEURONS];
    assign w_right[n]   = spike_record[(n + 1) % N_NEURONS];
  end

  // Membrane update for the neuron currently selected by r_idx
  always_comb begin
    w_in = '0;
    if (w_ext_bit[r_idx]) w_in = w_in + SW'(W_EXT);
    if (w_left[r_idx])    w_in = w_in + SW'(W_REC);
    if (w_right[r_idx])   w_in = w_in + SW'(W_REC);
    w_v_ext = SW'(r_v[r_idx]);
    w_v_new = w_v_ext - (w_v_ext >> LEAK_SHIFT) + w_in;
    if (w_v_new > SW'(c_v_max)) w_v_sat = c_v_max;
    else                        w_v_sat = w_v_new[V_WIDTH-1:0];
    w_refr = (r_ref[r_idx] != '0);
    w_fire = !w_refr && (SW'(w_v_sat) >= SW'(THRESH));
  end

  // Readout: signed weight sum over the neurons that fired this step
  always_comb begin
    w_out_next = '0;
    w_acc      = 0;
    for (int k = 0; k < N_OUT; k++) begin
      w_acc = 0;
      for (int i = 0; i < N_NEURONS; i++) begin
        if (r_shadow[i]) w_acc = w_acc + int'(r_w[k][i]);
      end
      w_out_next[k] = (w_acc >= OUT_THRESH);
    end
  end

  // Step sequencing, input latching and spike bookkeeping
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state      <= c_idle;
      r_idx        <= '0;
      r_ext        <= '0;
      r_write      <= 1'b0;
      r_teacher    <= '0;
      r_shadow     <= '0;
      spike_record <= '0;
      out_spikes   <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (w_accept) begin
            r_ext     <= ext_in;
            r_write   <= write;
            r_teacher <= teacher;
            r_idx     <= '0;
            r_shadow  <= '0;
            r_state   <= c_update;
          end
        end
        c_update: begin
          r_shadow[r_idx] <= w_fire;
          if (r_idx == IW'(N_NEURONS - 1)) r_state <= c_readout;
          else                             r_idx   <= r_idx + IW'(1);
        end
        c_readout: begin
          spike_record <= r_shadow;
          out_spikes   <= w_out_next;
          r_state      <= r_write ? c_learn : c_done;
        end
        c_learn: r_state <= c_done;
        c_done:  r_state <= c_idle;
        default: r_state <= c_idle;
      endcase
    end
  end

  // Membrane and refractory state, one neuron written per UPDATE cycle
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        r_v[i]   <= '0;
        r_ref[i] <= '0;
      end
    end else if (r_state == c_update) begin
      if (w_refr) begin
        r_v[r_idx]   <= '0;
        r_ref[r_idx] <= r_ref[r_idx] - RW'(1);
      end else if (w_fire) begin
        r_v[r_idx]   <= '0;
        r_ref[r_idx] <= RW'(REFRAC);
      end else begin
        r_v[r_idx]   <= w_v_sat;
      end
    end
  end

  // Teacher-driven weight nudging with saturation, all weights in parallel
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int k = 0; k < N_OUT; k++) begin
        for (int i = 0; i < N_NEURONS; i++) begin
          r_w[k][i] <= c_w_init;
        end
      end
    end else if (r_state == c_learn) begin
      for (int k = 0; k < N_OUT; k++) begin
        for (int i = 0; i < N_NEURONS; i++) begin
          if (spike_record[i]) begin
            if (r_teacher[k] && !out_spikes[k] && (r_w[k][i] != c_w_max))
              r_w[k][i] <= r_w[k][i] + c_w_one;
            else if (!r_teacher[k] && out_spikes[k] && (r_w[k][i] != c_w_min))
              r_w[k][i] <= r_w[k][i] - c_w_one;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsm_reservoir_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_lsm_reservoir_param
// Description : Scoreboard bench for lsm_reservoir_param. Expected spike
//               records, readouts and latencies are queued when a step is
//               requested and compared when step_done is observed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsm_reservoir_param;

  typedef struct packed {
    logic [15:0] sr;
    logic [1:0]  os;
    int          lat;
  } exp_t;

  logic        clock;
  logic        reset;
  logic [7:0]  ext_in;
  logic        step_valid;
  logic        step_ready;
  logic        write;
  logic [1:0]  teacher;
  logic [15:0] spike_record;
  logic [1:0]  out_spikes;
  logic        step_done;

  logic        s_valid;
  logic        s_ready;
  logic [3:0]  s_ext;
  logic        s_write;
  logic [1:0]  s_teacher;
  logic [3:0]  s_sr;
  logic [1:0]  s_out;
  logic        s_done;

  exp_t        exp_q[$];
  logic [1:0]  sat_q[$];
  int          n_cmp;
  int          n_fail;
  int          step_no;

  lsm_reservoir_param u_dut (
    .clock        (clock),
    .reset        (reset),
    .ext_in       (ext_in),
    .step_valid   (step_valid),
    .step_ready   (step_ready),
    .write        (write),
    .teacher      (teacher),
    .spike_record (spike_record),
    .out_spikes   (out_spikes),
    .step_done    (step_done)
  );

  // Small reservoir that fires every step, used to drive weights to the floor
  lsm_reservoir_param #(
    .N_NEURONS  (4),
    .N_EXT      (4),
    .N_OUT      (2),
    .THRESH     (1),
    .REFRAC     (0),
    .OUT_THRESH (-100)
  ) u_sat (
    .clock        (clock),
    .reset        (reset),
    .ext_in       (s_ext),
    .step_valid   (s_valid),
    .step_ready   (s_ready),
    .write        (s_write),
    .teacher      (s_teacher),
    .spike_record (s_sr),
    .out_spikes   (s_out),
    .step_done    (s_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Request one step and return what the DUT reports when it completes
  task automatic run_step(input logic [7:0] ext, input logic wr, input logic [1:0] tch,
                          output logic [15:0] sr, output logic [1:0] os,
                          output int lat, output bit to);
    int w;
    to  = 1'b0;
    lat = 0;
    sr  = '0;
    os  = '0;
    @(negedge clock);
    w = 0;
    while (!step_ready && w < 100) begin
      @(negedge clock);
      w++;
    end
    if (!step_ready) begin
      to = 1'b1;
      return;
    end
    ext_in = ext; write = wr; teacher = tch; step_valid = 1'b1;
    @(posedge clock);
    #1 step_valid = 1'b0;
    do begin
      @(negedge clock);
      lat++;
    end while (!step_done && lat < 100);
    if (!step_done) to = 1'b1;
    sr = spike_record;
    os = out_spikes;
  endtask

  task automatic test_reset();
    reset = 1'b0; step_valid = 1'b0; ext_in = '0; write = 1'b0; teacher = '0;
    s_valid = 1'b0; s_ext = '0; s_write = 1'b0; s_teacher = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    n_cmp++; if (step_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", step_ready); end
    n_cmp++; if (spike_record !== 16'h0000) begin n_fail++; $display("FAIL reset_sr got %h want 0000", spike_record); end
    n_cmp++; if (out_spikes !== 2'b00) begin n_fail++; $display("FAIL reset_out got %b want 00", out_spikes); end
    n_cmp++; if (step_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", step_done); end
  endtask

  // Push one expectation, run the step, pop and compare
  task automatic test_steps(input int count, input logic [15:0] last_sr, input logic [1:0] last_os,
                            input logic last_wr, input logic [1:0] last_tch);
    logic [15:0] sr;
    logic [1:0]  os;
    int          lat;
    bit          to;
    exp_t        e;
    logic        wr;
    logic [1:0]  tch;
    for (int s = 1; s <= count; s++) begin
      step_no++;
      wr  = (s == count) ? last_wr : 1'b0;
      tch = (s == count) ? last_tch : 2'b00;
      e.sr  = (s == count) ? last_sr : 16'h0000;
      e.os  = (s == count) ? last_os : 2'b00;
      e.lat = wr ? 19 : 18;
      exp_q.push_back(e);
      run_step(8'hFF, wr, tch, sr, os, lat, to);
      e = exp_q.pop_front();
      if (to) begin
        n_cmp++; n_fail++;
        $display("FAIL step%0d_timeout no step_done within bound", step_no);
      end else begin
        n_cmp++; if (sr !== e.sr) begin n_fail++; $display("FAIL step%0d_sr got %h want %h", step_no, sr, e.sr); end
        n_cmp++; if (os !== e.os) begin n_fail++; $display("FAIL step%0d_out got %b want %b", step_no, os, e.os); end
        n_cmp++; if (lat !== e.lat) begin n_fail++; $display("FAIL step%0d_latency got %0d want %0d", step_no, lat, e.lat); end
      end
    end
  endtask

  // Charge from rest: five silent steps then a full-ring spike
  task automatic test_charge();
    test_steps(6, 16'hFFFF, 2'b11, 1'b0, 2'b00);
  endtask

  // Refractory steps, recharge, learning on a firing step, then weakened readout
  task automatic test_refractory_learn();
    test_steps(8, 16'hFFFF, 2'b11, 1'b1, 2'b01);
    test_steps(8, 16'hFFFF, 2'b01, 1'b0, 2'b00);
  endtask

  task automatic test_reset_mid();
    int done_seen;
    int ready_low;
    @(negedge clock);
    ext_in = 8'hFF; write = 1'b0; teacher = 2'b00; step_valid = 1'b1;
    @(posedge clock);
    #1 step_valid = 1'b0;
    repeat (7) @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    n_cmp++; if (step_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready got %b want 1", step_ready); end
    n_cmp++; if (spike_record !== 16'h0000) begin n_fail++; $display("FAIL midreset_sr got %h want 0000", spike_record); end
    n_cmp++; if (out_spikes !== 2'b00) begin n_fail++; $display("FAIL midreset_out got %b want 00", out_spikes); end
    done_seen = 0; ready_low = 0;
    for (int i = 0; i < 25; i++) begin
      if (step_done) done_seen++;
      if (!step_ready) ready_low++;
      @(negedge clock);
    end
    n_cmp++; if (done_seen != 0) begin n_fail++; $display("FAIL midreset_no_done got %0d pulses want 0", done_seen); end
    n_cmp++; if (ready_low != 0) begin n_fail++; $display("FAIL midreset_idle got %0d busy cycles want 0", ready_low); end
    step_no = 0;
    test_steps(6, 16'hFFFF, 2'b11, 1'b0, 2'b00);
  endtask

  task automatic test_back_to_back();
    int acc_cnt, done_cnt, last_acc, bad_int, dbl;
    logic prev_done;
    acc_cnt = 0; done_cnt = 0; last_acc = -1; bad_int = 0; dbl = 0; prev_done = 1'b0;
    @(negedge clock);
    ext_in = 8'hFF; write = 1'b0; teacher = 2'b00; step_valid = 1'b1;
    for (int i = 0; i < 57; i++) begin
      if (i > 0) @(negedge clock);
      if (step_ready) begin
        if (last_acc >= 0 && (i - last_acc) != 19) bad_int++;
        last_acc = i;
        acc_cnt++;
      end
      if (step_done) begin
        done_cnt++;
        if (prev_done) dbl++;
      end
      prev_done = step_done;
    end
    step_valid = 1'b0;
    n_cmp++; if (acc_cnt != 3) begin n_fail++; $display("FAIL b2b_accepts got %0d want 3", acc_cnt); end
    n_cmp++; if (bad_int != 0) begin n_fail++; $display("FAIL b2b_interval got %0d bad gaps want 0", bad_int); end
    n_cmp++; if (done_cnt != 3) begin n_fail++; $display("FAIL b2b_done_count got %0d want 3", done_cnt); end
    n_cmp++; if (dbl != 0) begin n_fail++; $display("FAIL b2b_done_width got %0d double pulses want 0", dbl); end
    repeat (3) @(negedge clock);
  endtask

  task automatic test_saturation();
    int w, lat;
    logic [1:0] e;
    logic signed [3:0] wv;
    logic signed [3:0] w_floor;
    logic signed [3:0] w_keep;
    w_floor = -4'sd8;
    w_keep  = 4'sd1;
    for (int s = 0; s < 12; s++) begin
      sat_q.push_back(2'b11);
      @(negedge clock);
      w = 0;
      while (!s_ready && w < 50) begin @(negedge clock); w++; end
      s_ext = 4'hF; s_write = 1'b1; s_teacher = 2'b01; s_valid = 1'b1;
      @(posedge clock);
      #1 s_valid = 1'b0;
      lat = 0;
      do begin @(negedge clock); lat++; end while (!s_done && lat < 50);
      e = sat_q.pop_front();
      n_cmp++;
      if (!s_done || s_out !== e || s_sr !== 4'hF) begin
        n_fail++;
        $display("FAIL sat_step%0d got done=%b out=%b sr=%h want done=1 out=%b sr=f", s, s_done, s_out, s_sr, e);
      end
    end
    for (int i = 0; i < 4; i++) begin
      wv = u_sat.r_w[1][i];
      n_cmp++; if (wv !== w_floor) begin n_fail++; $display("FAIL sat_w1_%0d got %0d want %0d", i, wv, w_floor); end
      wv = u_sat.r_w[0][i];
      n_cmp++; if (wv !== w_keep) begin n_fail++; $display("FAIL sat_w0_%0d got %0d want %0d", i, wv, w_keep); end
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; step_no = 0;
    test_reset();
    test_charge();
    test_refractory_learn();
    test_reset_mid();
    test_back_to_back();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
